axi2iob: RTL and testbench
==========================

Name: axi2iob

Overview:
- AXI4-full slave to IOb native master bridge: accepts INCR bursts from an external AXI master and replays each beat as one native access on the m_* port.
- Complement of the IOb-to-AXI master bridge; lets an AXI interconnect reach IOb native peripherals and memories.
- One burst in service at a time. One native access outstanding. Read and write share the native port under round-robin arbitration.

Parameters:
- ADDR_W, 32, native byte-address width.
- DATA_W, 32, data width on both AXI and native sides; must be 32, 64 or 128.
- AXI_ID_W, 1, AXI ID width.
- AXI_LEN_W, 8, AXI burst-length field width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- s_axi_awid / s_axi_arid  input  AXI_ID_W  write/read burst ID.
- s_axi_awaddr / s_axi_araddr  input  ADDR_W  burst start byte address.
- s_axi_awlen / s_axi_arlen  input  AXI_LEN_W  beats minus 1.
- s_axi_awvalid / s_axi_arvalid  input  1  address valid.
- s_axi_awready / s_axi_arready  output  1  address accept.
- s_axi_wdata  input  DATA_W  write beat data.
- s_axi_wstrb  input  DATA_W/8  write byte enables.
- s_axi_wlast  input  1  last write beat.
- s_axi_wvalid  input  1  write beat valid.
- s_axi_wready  output  1  write beat accept.
- s_axi_bid / s_axi_rid  output  AXI_ID_W  echoed burst ID.
- s_axi_bresp / s_axi_rresp  output  2  response; 00 OKAY, 10 SLVERR.
- s_axi_bvalid  output  1  write response valid.
- s_axi_bready  input  1  write response accept.
- s_axi_rdata  output  DATA_W  read beat data.
- s_axi_rlast  output  1  last read beat.
- s_axi_rvalid  output  1  read beat valid.
- s_axi_rready  input  1  read beat accept.
- m_valid  output  1  native request; held until m_ready.
- m_addr  output  ADDR_W  native byte address, word aligned.
- m_wdata  output  DATA_W  native write data.
- m_wstrb  output  DATA_W/8  native byte enables; all zero means read.
- m_rdata  input  DATA_W  native read data; valid in the m_ready cycle of a read.
- m_ready  input  1  native access complete.

Behaviour:
- Burst type is always INCR with full-width beats. AxSIZE, AxBURST and the lock/cache/prot/qos fields do not exist on this block; the wrapper ties them off.
- Reset: every output is 0; state is IDLE; last_grant = READ. Reset mid-burst aborts the burst with no response.

State machine: IDLE, WR_DATA, WR_ACC, WR_RESP, RD_ACC, RD_DATA.

IDLE and arbitration:
- awready = IDLE & awvalid & pick_wr; arready = IDLE & arvalid & ~pick_wr (combinational).
- pick_wr = awvalid & (~arvalid | last_grant==READ). With both valid out of reset, write wins first.
- On handshake: latch ID, addr with low log2(DATA_W/8) bits cleared, len. Clear beat counter and err flag. Update last_grant.
- Next state: WR_DATA for a write, RD_ACC for a read.

Write path:
- WR_DATA: wready = 1. On the W handshake, latch wdata/wstrb. err |= (wlast != (cnt==len)).
  - If wstrb != 0, go to WR_ACC.
  - If wstrb == 0, skip the native access and advance the beat immediately.
- WR_ACC: m_valid = 1 with latched addr/wdata/wstrb, held until m_ready. Then advance the beat.
- Advance beat: addr += DATA_W/8, wrapping modulo 2^ADDR_W; cnt += 1. If the beat was last (cnt==len), go to WR_RESP; otherwise return to WR_DATA.
- WR_RESP: bvalid = 1, bid = latched ID, bresp = err ? SLVERR : OKAY. Held until bready, then IDLE.

Read path:
- RD_ACC: m_valid = 1, m_wstrb = 0. On m_ready, register m_rdata into rdata; go to RD_DATA.
- RD_DATA: rvalid = 1, rid = latched ID, rresp = OKAY, rlast = (cnt==len).
  - rdata is held stable while rvalid & ~rready.
  - On rready: advance addr/cnt, then RD_ACC, or IDLE after the last beat.

Timing and boundary rules:
- Minimum latency: 2 cycles per write beat, 2 cycles per read beat; one idle cycle between bursts.
- m_valid never deasserts before m_ready. Native address, data and strobes are stable while m_valid is high.
- len = 0: single beat. len = 2^AXI_LEN_W - 1: 256 beats; the counter must not overflow before the compare.
- wlast early or missing: beat count still follows len; bresp = SLVERR.
- W beats arriving before the AW handshake are not accepted (wready = 0 outside WR_DATA).

Test Plan:
- Reset, then awaddr=0x103, awlen=3, four full-strobe beats with wlast on beat 4 -> m_addr 0x100, 0x104, 0x108, 0x10C in order; one bvalid with bresp=00 and bid echoed.
- Read araddr=0x200, arlen=1, arid=1, memory model returns 0xA5A5A5A5 then 0x5A5A5A5A; rready low for 3 cycles on beat 1 -> rdata held stable; rlast only on beat 2; rresp=00, rid=1.
- awvalid and arvalid asserted in the same cycle repeatedly -> write, read, write, read serviced alternately; no starvation.
- Write burst awlen=2 with wlast on beat 2 -> three native writes, bresp=10; following read burst is unaffected.
- Write beat with wstrb=0 in the middle of a 3-beat burst -> only 2 native accesses; addresses skip by 8.
- rst asserted while m_valid is high in RD_ACC -> next cycle all outputs 0; a new AR is accepted normally afterwards.

Source files
------------

// File: rtl/axi2iob.sv
// axi2iob: AXI4-full slave to IOb native master bridge.
// Services one INCR burst at a time and replays each beat as a single native
// access. Read and write address channels share the native port through
// round-robin arbitration in IDLE.
module axi2iob #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int AXI_ID_W  = 1,
    parameter int AXI_LEN_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    // write address
    input  logic [AXI_ID_W-1:0]   s_axi_awid,
    input  logic [ADDR_W-1:0]     s_axi_awaddr,
    input  logic [AXI_LEN_W-1:0]  s_axi_awlen,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    // write data
    input  logic [DATA_W-1:0]     s_axi_wdata,
    input  logic [DATA_W/8-1:0]   s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    // write response
    output logic [AXI_ID_W-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    // read address
    input  logic [AXI_ID_W-1:0]   s_axi_arid,
    input  logic [ADDR_W-1:0]     s_axi_araddr,
    input  logic [AXI_LEN_W-1:0]  s_axi_arlen,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    // read data
    output logic [AXI_ID_W-1:0]   s_axi_rid,
    output logic [DATA_W-1:0]     s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    // native master
    output logic                  m_valid,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic                  m_ready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_DATA = 3'd1,
        WR_ACC  = 3'd2,
        WR_RESP = 3'd3,
        RD_ACC  = 3'd4,
        RD_DATA = 3'd5
    } state_t;

    state_t                 state_q;
    logic                   last_wr_q;   // 1: last grant went to the write channel
    logic [AXI_ID_W-1:0]    id_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [AXI_LEN_W-1:0]   len_q;
    logic [AXI_LEN_W-1:0]   cnt_q;
    logic                   err_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [STRB_W-1:0]      wstrb_q;
    logic [DATA_W-1:0]      rdata_q;

    logic                   pick_wr;
    logic                   beat_last;
    logic [ADDR_W-1:0]      addr_d;
    logic [AXI_LEN_W-1:0]   cnt_d;

    // Round-robin: a write wins unless a read is also pending and the
    // write channel was granted last.
    assign pick_wr   = s_axi_awvalid & (~s_axi_arvalid | ~last_wr_q);
    assign beat_last = (cnt_q == len_q);
    // Compare happens on the pre-increment count, so a wrap of cnt_d after
    // the final beat of a maximal burst is never observed.
    assign addr_d    = addr_q + ADDR_W'(STRB_W);
    assign cnt_d     = cnt_q + AXI_LEN_W'(1);

    assign s_axi_awready = (state_q == IDLE) & s_axi_awvalid & pick_wr;
    assign s_axi_arready = (state_q == IDLE) & s_axi_arvalid & ~pick_wr;
    assign s_axi_wready  = (state_q == WR_DATA);

    assign s_axi_bvalid  = (state_q == WR_RESP);
    assign s_axi_bid     = id_q;
    assign s_axi_bresp   = {err_q, 1'b0};

    assign s_axi_rvalid  = (state_q == RD_DATA);
    assign s_axi_rid     = id_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;
    assign s_axi_rlast   = (state_q == RD_DATA) & beat_last;

    // Native request fields come straight from registers, so they stay
    // stable for as long as m_valid is held.
    assign m_valid = (state_q == WR_ACC) | (state_q == RD_ACC);
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;
    assign m_wstrb = (state_q == WR_ACC) ? wstrb_q : '0;

    // Burst sequencer: arbitration, beat counting and native handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_axi_awready) begin
                        id_q      <= s_axi_awid;
                        addr_q    <= {s_axi_awaddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        len_q     <= s_axi_awlen;
                        cnt_q     <= '0;
                        err_q     <= 1'b0;
                        last_wr_q <= 1'b1;
                        state_q   <= WR_DATA;
                    end else if (s_axi_arready) begin
                        id_q      <= s_axi_arid;
                        addr_q    <= {s_axi_araddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        len_q     <= s_axi_arlen;
                        cnt_q     <= '0;
                        err_q     <= 1'b0;
                        last_wr_q <= 1'b0;
                        state_q   <= RD_ACC;
                    end
                end
                WR_DATA: begin
                    if (s_axi_wvalid) begin
                        wdata_q <= s_axi_wdata;
                        wstrb_q <= s_axi_wstrb;
                        if (s_axi_wlast != beat_last) err_q <= 1'b1;
                        if (|s_axi_wstrb) begin
                            state_q <= WR_ACC;
                        end else begin
                            // empty strobe: nothing to write, just step the beat
                            addr_q  <= addr_d;
                            cnt_q   <= cnt_d;
                            state_q <= beat_last ? WR_RESP : WR_DATA;
                        end
                    end
                end
                WR_ACC: begin
                    if (m_ready) begin
                        addr_q  <= addr_d;
                        cnt_q   <= cnt_d;
                        state_q <= beat_last ? WR_RESP : WR_DATA;
                    end
                end
                WR_RESP: begin
                    if (s_axi_bready) state_q <= IDLE;
                end
                RD_ACC: begin
                    if (m_ready) begin
                        rdata_q <= m_rdata;
                        state_q <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (s_axi_rready) begin
                        addr_q  <= addr_d;
                        cnt_q   <= cnt_d;
                        state_q <= beat_last ? IDLE : RD_ACC;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi2iob.sv
// Testbench for axi2iob: directed scenarios plus random bursts, checked
// against a burst-level memory model and an expected native access list.
module tb_axi2iob;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:0]  s_axi_awid = '0, s_axi_arid = '0, s_axi_bid, s_axi_rid;
    logic [31:0] s_axi_awaddr = '0, s_axi_araddr = '0;
    logic [7:0]  s_axi_awlen = '0, s_axi_arlen = '0;
    logic        s_axi_awvalid = 1'b0, s_axi_arvalid = 1'b0, s_axi_awready, s_axi_arready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wlast = 1'b0, s_axi_wvalid = 1'b0, s_axi_wready;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic        s_axi_bvalid, s_axi_bready = 1'b0;
    logic [31:0] s_axi_rdata;
    logic        s_axi_rlast, s_axi_rvalid, s_axi_rready = 1'b0;
    logic        m_valid, m_ready;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axi2iob #(.ADDR_W(32), .DATA_W(32), .AXI_ID_W(1), .AXI_LEN_W(8)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .m_ready(m_ready)
    );

    wire [112:0] all_outs = {s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bid, s_axi_bresp,
                             s_axi_bvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
                             s_axi_rvalid, m_valid, m_addr, m_wdata, m_wstrb};

    // golden memory (burst semantics) and the native-side memory (what the DUT did)
    logic [31:0] gmem [logic [31:0]];
    logic [31:0] nmem [logic [31:0]];
    logic [67:0] nlog [$];          // {addr, wdata, wstrb} per completed native access
    bit          order [$];         // 1 = write burst granted, 0 = read burst granted
    bit          hold_rdy = 1'b0;

    // write-beat stimulus tables, filled before each do_write
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    logic        wl [256];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A17_C0DE;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] s);
        for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = d[8*b +: 8];
        return o;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tmo(input string tag);
        n_chk++;
        n_fail++;
        $display("FAIL timeout waiting for %s", tag);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "timeout");
    endtask

    // Native slave: random ready, serves reads from nmem, logs each access
    // and checks request stability while it is stalled.
    initial begin
        logic        pv;
        logic [31:0] pa, pd;
        logic [3:0]  ps;
        pv = 1'b0; pa = '0; pd = '0; ps = '0;
        m_ready = 1'b0;
        m_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_ready = 1'b0;
                pv = 1'b0;
            end else begin
                if (pv && m_ready) begin
                    nlog.push_back({pa, pd, ps});
                    if (ps != 4'h0)
                        nmem[pa] = merge(nmem.exists(pa) ? nmem[pa] : dflt(pa), pd, ps);
                end else if (pv) begin
                    chk("m_hold", {m_valid, m_addr, m_wdata, m_wstrb}, {1'b1, pa, pd, ps});
                end
                m_ready = 1'b0;
                pv = m_valid; pa = m_addr; pd = m_wdata; ps = m_wstrb;
                if (m_valid && !hold_rdy && $urandom_range(0, 3) != 0) begin
                    m_ready = 1'b1;
                    m_rdata = nmem.exists(m_addr) ? nmem[m_addr] : dflt(m_addr);
                end else begin
                    m_rdata = $urandom;
                end
            end
        end
    end

    task automatic fill_w(input int len, input int zero_pct);
        for (int i = 0; i <= len; i++) begin
            wd[i] = $urandom;
            ws[i] = ($urandom_range(0, 99) < zero_pct) ? 4'h0 : 4'($urandom_range(1, 15));
            wl[i] = (i == len);
        end
    endtask

    task automatic do_write(input logic id, input logic [31:0] addr, input int len, input bit logchk);
        logic [31:0] a;
        logic [67:0] exq [$];
        bit          err;
        int          n;
        // reference: each beat with a non-empty strobe is one native write
        a = {addr[31:2], 2'b00};
        err = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (wl[i] != (i == len)) err = 1'b1;
            if (ws[i] != 4'h0) begin
                exq.push_back({a, wd[i], ws[i]});
                gmem[a] = merge(gmem.exists(a) ? gmem[a] : dflt(a), wd[i], ws[i]);
            end
            a = a + 32'd4;
        end
        if (logchk) nlog.delete();
        @(negedge clk);
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awvalid = 1'b1;
        #1;
        n = 0;
        while (!s_axi_awready) begin @(negedge clk); #1; if (++n > 5000) tmo("awready"); end
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        order.push_back(1'b1);
        for (int i = 0; i <= len; i++) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            @(negedge clk);
            s_axi_wdata = wd[i]; s_axi_wstrb = ws[i]; s_axi_wlast = wl[i]; s_axi_wvalid = 1'b1;
            #1;
            n = 0;
            while (!s_axi_wready) begin @(negedge clk); #1; if (++n > 5000) tmo("wready"); end
            @(posedge clk); #1;
            s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        end
        n = 0;
        while (!s_axi_bvalid) begin @(negedge clk); #1; if (++n > 5000) tmo("bvalid"); end
        repeat ($urandom_range(0, 2)) begin @(negedge clk); #1; chk("bvalid_hold", s_axi_bvalid, 1'b1); end
        chk("bid", s_axi_bid, id);
        chk("bresp", s_axi_bresp, err ? 2'b10 : 2'b00);
        s_axi_bready = 1'b1;
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
        if (logchk) begin
            chk("nwr_count", nlog.size(), exq.size());
            for (int i = 0; i < exq.size() && i < nlog.size(); i++) chk("nwr_acc", nlog[i], exq[i]);
        end
    endtask

    task automatic do_read(input logic id, input logic [31:0] addr, input int len,
                           input int stall0, input bit logchk);
        logic [31:0] a, e;
        int          n;
        if (logchk) nlog.delete();
        @(negedge clk);
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arvalid = 1'b1;
        #1;
        n = 0;
        while (!s_axi_arready) begin @(negedge clk); #1; if (++n > 5000) tmo("arready"); end
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        order.push_back(1'b0);
        a = {addr[31:2], 2'b00};
        for (int i = 0; i <= len; i++) begin
            e = gmem.exists(a) ? gmem[a] : dflt(a);
            n = 0;
            while (!s_axi_rvalid) begin @(negedge clk); #1; if (++n > 5000) tmo("rvalid"); end
            chk("rdata", s_axi_rdata, e);
            chk("rlast", s_axi_rlast, i == len);
            chk("rid_rresp", {s_axi_rid, s_axi_rresp}, {id, 2'b00});
            repeat ((i == 0) ? stall0 : $urandom_range(0, 1)) begin
                @(negedge clk); #1;
                chk("rdata_hold", {s_axi_rvalid, s_axi_rdata}, {1'b1, e});
            end
            s_axi_rready = 1'b1;
            @(posedge clk); #1;
            s_axi_rready = 1'b0;
            a = a + 32'd4;
        end
        if (logchk) begin
            chk("nrd_count", nlog.size(), len + 1);
            a = {addr[31:2], 2'b00};
            for (int i = 0; i <= len && i < nlog.size(); i++) begin
                chk("nrd_acc", {nlog[i][67:36], nlog[i][3:0]}, {a, 4'h0});
                a = a + 32'd4;
            end
        end
    endtask

    initial begin
        int n;
        logic [31:0] ra;
        // reset state
        repeat (3) @(negedge clk);
        chk("reset_outs", all_outs, 113'd0);
        rst = 1'b0;

        // W beats are not accepted before the AW handshake
        @(negedge clk);
        s_axi_wvalid = 1'b1; s_axi_wlast = 1'b1; s_axi_wstrb = 4'hF;
        #1 chk("wready_idle", s_axi_wready, 1'b0);
        @(negedge clk);
        chk("wready_idle2", {s_axi_wready, m_valid}, 2'b00);
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;

        // 4-beat write from unaligned 0x103
        fill_w(3, 0);
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        do_write(1'b1, 32'h0000_0103, 3, 1'b1);
        chk("wr4_addr0", nlog.size() > 0 ? nlog[0][67:36] : 32'hX, 32'h100);
        chk("wr4_addr3", nlog.size() > 3 ? nlog[3][67:36] : 32'hX, 32'h10C);

        // 2-beat read with a 3-cycle stall on beat 1
        gmem[32'h200] = 32'hA5A5_A5A5; nmem[32'h200] = 32'hA5A5_A5A5;
        gmem[32'h204] = 32'h5A5A_5A5A; nmem[32'h204] = 32'h5A5A_5A5A;
        do_read(1'b1, 32'h200, 1, 3, 1'b1);

        // reset while a read is stalled in its native access
        hold_rdy = 1'b1;
        @(negedge clk);
        s_axi_arid = 1'b0; s_axi_araddr = 32'h300; s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1;
        #1;
        n = 0;
        while (!s_axi_arready) begin @(negedge clk); #1; if (++n > 100) tmo("arready_rst"); end
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        @(negedge clk); #1;
        chk("rd_acc_pending", {m_valid, m_wstrb}, {1'b1, 4'h0});
        rst = 1'b1;
        #1 chk("mid_reset_outs", all_outs, 113'd0);
        @(negedge clk);
        chk("mid_reset_outs2", all_outs, 113'd0);
        rst = 1'b0;
        hold_rdy = 1'b0;
        do_read(1'b1, 32'h300, 1, 0, 1'b1);

        // simultaneous AW/AR: grants alternate, write first after a read
        order.delete();
        fill_w(1, 0);
        fork
            begin do_write(1'b0, 32'h1000, 1, 1'b0); do_write(1'b1, 32'h1010, 1, 1'b0); end
            begin do_read(1'b1, 32'h2000, 1, 0, 1'b0); do_read(1'b0, 32'h2010, 1, 0, 1'b0); end
        join
        chk("arb_order", {order.size() == 4 ? 1'b1 : 1'b0, order[0], order[1], order[2], order[3]},
            5'b1_1010);

        // early wlast: three native writes, SLVERR, subsequent read unaffected
        fill_w(2, 0);
        wl[1] = 1'b1; wl[2] = 1'b0;
        do_write(1'b0, 32'h500, 2, 1'b1);
        do_read(1'b0, 32'h500, 2, 0, 1'b1);

        // empty strobe on the middle beat: 2 native writes 8 bytes apart
        fill_w(2, 0);
        ws[1] = 4'h0;
        do_write(1'b1, 32'h600, 2, 1'b1);
        chk("skip_addrs", nlog.size() == 2 ? {nlog[0][67:36], nlog[1][67:36]} : 64'hX,
            {32'h600, 32'h608});

        // address wrap at the top of the space
        fill_w(3, 10);
        do_write(1'b0, 32'hFFFF_FFF9, 3, 1'b1);
        do_read(1'b1, 32'hFFFF_FFF8, 3, 0, 1'b1);

        // maximal burst length
        fill_w(255, 15);
        do_write(1'b1, 32'h8000, 255, 1'b1);
        do_read(1'b0, 32'h8000, 255, 0, 1'b1);

        // random mix of bursts over a small overlapping window
        for (int t = 0; t < 24; t++) begin
            ra = 32'h4000 + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
            n = $urandom_range(0, 7);
            if ($urandom_range(0, 1) != 0) begin
                fill_w(n, 20);
                if ($urandom_range(0, 3) == 0) wl[$urandom_range(0, n)] ^= 1'b1;
                do_write(1'($urandom), ra, n, 1'b1);
            end else begin
                do_read(1'($urandom), ra, n, $urandom_range(0, 2), 1'b1);
            end
        end

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
